rv32i_mem_sequencer: RTL
========================

Name: rv32i_mem_sequencer

Overview:
Multi-cycle controller that shares one single-ported memory between instruction fetch and data load/store for the RV32I core.
It holds the instruction register that feeds the decoder, and sequences fetch, decode, data access and commit.
It issues a one-cycle commit pulse, which gates the PC update and the register-file write enable.
It sits between the core datapath and the memory/bus interface, with a watchdog on memory responses.

Parameters:
TIMEOUT, 16, max cycles a request may wait for mem_ready before fault; 0 disables the watchdog; legal range 0..255
NOP_INSTR, 32'h00000013, reset/fault value of the instruction register (addi x0,x0,0)

Ports:
sys_clk  in  1  system clock, rising edge
sys_reset  in  1  asynchronous, active-high reset
pc  in  32  current program counter from core
data_addr  in  32  load/store address (ALU result)
data_wdata  in  32  store data (rs2 value)
memloadf  in  1  decoded load flag, valid in DECODE/DATA
memstoref  in  1  decoded store flag, valid in DECODE/DATA
instruction  out  32  instruction register to decoder
load_data  out  32  latched load data to writeback mux
commit  out  1  one-cycle pulse: core updates pc, regfile write enabled
fault  out  1  sticky error flag
instr_count  out  32  retired-instruction counter
mem_req  out  1  memory request
mem_we  out  1  write enable for the request
mem_addr  out  32  request address
mem_wdata  out  32  write data
mem_ready  in  1  request accepted/completed this cycle
mem_rdata  in  32  read data, valid when mem_ready=1

Behaviour:
- Reset (async, immediate): state=IDLE, instruction=NOP_INSTR, load_data=0, commit=0, fault=0, instr_count=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-request drops mem_req at once; the memory must tolerate an abandoned request.
- All outputs decode from registered state/data; no combinational path from mem_ready to mem_req.
- States and transitions:
  - IDLE -> FETCH after one cycle.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: instruction<=mem_rdata, go to DECODE.
  - FETCH with pc[1:0]!=0: go directly to FAULT; no request is issued.
  - DECODE: one cycle for decoder/ALU to settle.
    - memloadf&memstoref -> FAULT.
    - memloadf|memstoref -> DATA.
    - Otherwise -> COMMIT.
  - DATA: mem_req=1, mem_we=memstoref, mem_addr=data_addr, mem_wdata=data_wdata. On mem_ready: if load, load_data<=mem_rdata; go to COMMIT.
  - COMMIT: commit=1 for exactly one cycle; instr_count<=instr_count+1 (wraps 2^32-1 -> 0); go to FETCH.
  - FAULT: terminal. fault=1, mem_req=0, commit=0; only sys_reset exits.
- Handshake: address/we/wdata stay stable while mem_req=1. The transfer completes on the rising edge where mem_req&mem_ready. mem_req is 0 in the following cycle (single-beat, no back-to-back requests).
- Watchdog:
  - Wait counter clears on entry to FETCH/DATA and increments each cycle without mem_ready.
  - If the counter reaches TIMEOUT-1 with mem_ready=0 -> FAULT.
  - mem_ready in the expiry cycle wins: the transfer completes and there is no fault.
- Latency, zero-wait memory (mem_ready high the first cycle of each request):
  - ALU instruction: 3 cycles (FETCH, DECODE, COMMIT).
  - Load/store: 4 cycles.
- Core inputs stay stable from DECODE through COMMIT, because the regfile and pc change only on commit.

Decomposition:
- Package rv32i_ctrl_pkg:
  - state enum: IDLE, FETCH, DECODE, DATA, COMMIT, FAULT.
  - NOP constant 32'h00000013.
  - watchdog counter width (8).
- Sub-module rv32i_mem_watchdog: clear/enable inputs, expire output, parameter TIMEOUT.

Test Plan:
- Reset, then zero-wait memory returning 32'h00500093 at pc=0 → FETCH→DECODE→COMMIT; commit pulses in cycle 3; instruction=32'h00500093; instr_count=1.
- Load with memloadf=1, data_addr=32'h100, mem_rdata=32'hDEADBEEF after 2 wait cycles → mem_we=0, mem_addr=32'h100; load_data=32'hDEADBEEF; single commit pulse.
- Store with data_addr=32'h104, data_wdata=32'h12345678 → mem_we=1, addr/wdata held stable across 3 wait cycles; mem_req drops the cycle after mem_ready.
- TIMEOUT=4, mem_ready never asserted → fault=1 after 4 request cycles; mem_req=0 thereafter; commit never pulses. Repeat with mem_ready in cycle 4 → no fault.
- pc=32'h2 → FAULT with no mem_req. memloadf=memstoref=1 in DECODE → FAULT.
- sys_reset asserted mid-DATA with mem_req=1 → all outputs return to reset values without waiting for a clock edge. After release, first fetch from the current pc.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle memory sequencer.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    DATA,
    COMMIT,
    FAULT
  } state_t;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          WDOG_W = 8;

endpackage

// File: rtl/rv32i_mem_watchdog.sv
// Counts cycles a memory request waits for mem_ready; flags expiry after TIMEOUT cycles.
module rv32i_mem_watchdog
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic sys_clk,
  input  logic sys_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset)   count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  // enable already excludes mem_ready, so a response in the expiry cycle wins.
  assign expire = (TIMEOUT != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/rv32i_mem_sequencer.sv
// Multi-cycle fetch/decode/data/commit sequencer sharing one memory port for an RV32I core.
module rv32i_mem_sequencer
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic [31:0] pc,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        memloadf,
  input  logic        memstoref,
  output logic [31:0] instruction,
  output logic [31:0] load_data,
  output logic        commit,
  output logic        fault,
  output logic [31:0] instr_count,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_t state, next_state;
  logic   fetch_ok;
  logic   req_active;
  logic   expire;

  assign fetch_ok   = (pc[1:0] == 2'b00);
  assign req_active = ((state == FETCH) && fetch_ok) || (state == DATA);

  // Clearing whenever idle is equivalent to clearing on entry: requests never run back-to-back.
  rv32i_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .clear     (!req_active),
    .enable    (req_active && !mem_ready),
    .expire    (expire)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) state <= IDLE;
    else           state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH: begin
        if (!fetch_ok)      next_state = FAULT;
        else if (mem_ready) next_state = DECODE;
        else if (expire)    next_state = FAULT;
      end
      DECODE: begin
        if (memloadf && memstoref)      next_state = FAULT;
        else if (memloadf || memstoref) next_state = DATA;
        else                            next_state = COMMIT;
      end
      DATA: begin
        if (mem_ready)   next_state = COMMIT;
        else if (expire) next_state = FAULT;
      end
      COMMIT:  next_state = FETCH;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  // Outputs depend on registered state and stable core inputs only, never on mem_ready.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    commit    = 1'b0;
    fault     = 1'b0;
    case (state)
      FETCH: begin
        if (fetch_ok) begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
      end
      DATA: begin
        mem_req   = 1'b1;
        mem_we    = memstoref;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      COMMIT:  commit = 1'b1;
      FAULT:   fault  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      instruction <= NOP_INSTR;
      load_data   <= '0;
      instr_count <= '0;
    end else begin
      if (next_state == FAULT)
        instruction <= NOP_INSTR;
      else if ((state == FETCH) && fetch_ok && mem_ready)
        instruction <= mem_rdata;
      if ((state == DATA) && mem_ready && memloadf)
        load_data <= mem_rdata;
      if (state == COMMIT)
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule
